// File: rtl/mil_ring_buffer.sv
// Transactional ring buffer for MIL-STD-1553 data words: pushes/pops advance
// tentative pointers and become visible/permanent on commit (or at once when idle).
module mil_ring_buffer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_req,
  output logic              push_done,
  input  logic              pop_req,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_done,
  input  logic              open,
  input  logic              commit,
  input  logic              rollback,
  output logic [ADDR_W:0]   mem_used,
  output logic [ADDR_W:0]   mem_free,
  output logic              dbgTxn
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  typedef enum logic {IDLE, TXN} state_t;

  state_t            state, stateNext;
  logic [ADDR_W:0]   wrC, rdC, wrT, rdT;
  logic [ADDR_W:0]   wrCNext, rdCNext, wrTNext, rdTNext;
  logic              pushAcc, popAcc;
  logic              pushDoneQ, popDoneQ;
  logic [DATA_W-1:0] rdWord;
  logic [DATA_W-1:0] mem [DEPTH];

  assign mem_used = wrC - rdC;
  assign mem_free = DEPTH_P - (wrT - rdC);
  assign dbgTxn   = (state == TXN);

  // Valid/ready: a request is accepted in the cycle req=1 and the side has room
  // (push) or a committed unread word (pop), unless rollback is asserted; the
  // matching done pulses exactly one cycle later.
  assign pushAcc = push_req && (mem_free != '0) && !rollback;
  assign popAcc  = pop_req && (rdT != wrC) && !rollback;

  always_comb begin
    stateNext = state;
    wrTNext   = pushAcc ? wrT + ONE : wrT;
    rdTNext   = popAcc  ? rdT + ONE : rdT;
    wrCNext   = wrC;
    rdCNext   = rdC;
    case (state)
      IDLE: begin
        wrCNext = wrTNext;
        rdCNext = rdTNext;
        // open alongside commit/rollback: the higher-priority no-op wins
        if (open && !commit && !rollback) stateNext = TXN;
      end
      TXN: begin
        if (rollback) begin
          wrTNext   = wrC;
          rdTNext   = rdC;
          stateNext = IDLE;
        end else if (commit) begin
          wrCNext   = wrTNext;
          rdCNext   = rdTNext;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wrC       <= '0;
      rdC       <= '0;
      wrT       <= '0;
      rdT       <= '0;
      pushDoneQ <= 1'b0;
      popDoneQ  <= 1'b0;
    end else begin
      state     <= stateNext;
      wrC       <= wrCNext;
      rdC       <= rdCNext;
      wrT       <= wrTNext;
      rdT       <= rdTNext;
      pushDoneQ <= pushAcc;
      popDoneQ  <= popAcc;
    end
  end

  // Storage array and its read register carry no reset so they map to block RAM.
  always_ff @(posedge clk) begin
    if (pushAcc) mem[wrT[ADDR_W-1:0]] <= push_data;
    if (popAcc)  rdWord <= mem[rdT[ADDR_W-1:0]];
  end

  assign push_done = pushDoneQ;
  assign pop_done  = popDoneQ;
  assign pop_data  = popDoneQ ? rdWord : '0;

endmodule

// File: tb/tb_mil_ring_buffer.sv
// Bench for mil_ring_buffer (ADDR_W=2): constant vector table, hand-written
// corner sequences, and random traffic checked against a queue-based model.
module tb_mil_ring_buffer;

  localparam int AW = 2;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic          clk, rst;
  logic [DW-1:0] push_data, pop_data;
  logic          push_req, push_done, pop_req, pop_done;
  logic          open, commit, rollback, dbgTxn;
  logic [AW:0]   mem_used, mem_free;

  mil_ring_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .push_data(push_data), .push_req(push_req),
    .push_done(push_done), .pop_req(pop_req), .pop_data(pop_data),
    .pop_done(pop_done), .open(open), .commit(commit), .rollback(rollback),
    .mem_used(mem_used), .mem_free(mem_free), .dbgTxn(dbgTxn)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // behavioural model: committed words, pending txn pushes, txn read count
  logic [DW-1:0] store[$];
  logic [DW-1:0] pend[$];
  int            readCnt;
  bit            inTxn;
  logic [DW-1:0] exp_q[$];

  task automatic drive(input logic pr, input logic [DW-1:0] pd, input logic qr,
                       input logic op, input logic cm, input logic rb);
    push_req = pr; push_data = pd; pop_req = qr;
    open = op; commit = cm; rollback = rb;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    store.delete(); pend.delete(); exp_q.delete();
    readCnt = 0; inTxn = 0;
  endtask

  // One model-checked cycle; called and returns at a falling edge.
  task automatic cyc(input logic pr, input logic [DW-1:0] pd, input logic qr,
                     input logic op, input logic cm, input logic rb, output logic acc);
    logic pAcc, qAcc;
    drive(pr, pd, qr, op, cm, rb);
    chk("mem_used", 32'(mem_used), store.size());
    chk("mem_free", 32'(mem_free), DEPTH - store.size() - pend.size());
    pAcc = pr && !rb && (DEPTH - store.size() - pend.size() > 0);
    qAcc = qr && !rb && (readCnt < store.size());
    if (qAcc) exp_q.push_back(store[readCnt]);
    @(posedge clk);
    if (rb) begin
      if (inTxn) begin pend.delete(); readCnt = 0; inTxn = 0; end
    end else begin
      if (pAcc) begin
        if (inTxn) pend.push_back(pd); else store.push_back(pd);
      end
      if (qAcc) begin
        if (inTxn) readCnt++; else void'(store.pop_front());
      end
      if (cm) begin
        if (inTxn) begin
          repeat (readCnt) void'(store.pop_front());
          foreach (pend[i]) store.push_back(pend[i]);
          pend.delete(); readCnt = 0; inTxn = 0;
        end
      end else if (op && !inTxn) inTxn = 1;
    end
    @(negedge clk);
    chk("push_done", 32'(push_done), 32'(pAcc));
    chk("pop_done", 32'(pop_done), 32'(qAcc));
    if (pop_done) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
    end
    acc = pAcc;
  endtask

  typedef struct {
    logic pr; logic [DW-1:0] pd; logic qr; logic op; logic cm; logic rb;
    logic ePush; logic ePop; logic [DW-1:0] eData; logic [AW:0] eUsed; logic [AW:0] eFree;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic pr, logic [DW-1:0] pd, logic qr, logic op, logic cm,
                              logic rb, logic ePush, logic ePop, logic [DW-1:0] eData,
                              logic [AW:0] eUsed, logic [AW:0] eFree);
    vec_t v;
    v.pr = pr; v.pd = pd; v.qr = qr; v.op = op; v.cm = cm; v.rb = rb;
    v.ePush = ePush; v.ePop = ePop; v.eData = eData; v.eUsed = eUsed; v.eFree = eFree;
    return v;
  endfunction

  logic          acc;
  logic [DW-1:0] w;

  initial begin
    // columns: pr pd qr op cm rb | push_done pop_done pop_data used free (after edge)
    vecs.push_back(mk(1, 16'h1111, 0, 0, 0, 0, 1, 0, 0, 1, 3));
    vecs.push_back(mk(1, 16'h2222, 0, 0, 0, 0, 1, 0, 0, 2, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 16'h1111, 1, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 16'h2222, 0, 4));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 16'hA001, 0, 0, 0, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, 16'hA002, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 16'hA003, 1, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 16'hA001, 2, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 2));
    vecs.push_back(mk(1, 16'hB001, 1, 0, 0, 0, 1, 1, 16'hA002, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 16'hA002, 1, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3));
    vecs.push_back(mk(1, 16'hC001, 0, 0, 1, 0, 1, 0, 0, 2, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 2));
    vecs.push_back(mk(1, 16'hC002, 0, 0, 0, 1, 0, 0, 0, 2, 2));
    vecs.push_back(mk(1, 16'hC003, 0, 0, 0, 1, 0, 0, 0, 2, 2));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2));
    vecs.push_back(mk(1, 16'hC004, 0, 0, 0, 0, 1, 0, 0, 3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 16'hA003, 2, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 16'hC001, 1, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 16'hC004, 0, 4));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 16'hD001, 0, 0, 0, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 3));

    // reset state, sampled while rst is still asserted
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_push_done", 32'(push_done), 0);
    chk("rst_pop_done", 32'(pop_done), 0);
    chk("rst_pop_data", 32'(pop_data), 0);
    chk("rst_mem_used", 32'(mem_used), 0);
    chk("rst_mem_free", 32'(mem_free), DEPTH);
    rst = 1'b0;

    // constant vector table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pr, vecs[i].pd, vecs[i].qr, vecs[i].op, vecs[i].cm, vecs[i].rb);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_push_done", i), 32'(push_done), 32'(vecs[i].ePush));
      chk($sformatf("vec%0d_pop_done", i), 32'(pop_done), 32'(vecs[i].ePop));
      if (vecs[i].ePop) chk($sformatf("vec%0d_pop_data", i), 32'(pop_data), 32'(vecs[i].eData));
      chk($sformatf("vec%0d_mem_used", i), 32'(mem_used), 32'(vecs[i].eUsed));
      chk($sformatf("vec%0d_mem_free", i), 32'(mem_free), 32'(vecs[i].eFree));
    end

    // full: four pushes land, the fifth waits until one pop frees a slot
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 16'hF000 + 16'(i), 0, 0, 0, 0, acc);
      chk("full_fill_acc", 32'(acc), 1);
    end
    cyc(1, 16'hF004, 0, 0, 0, 0, acc);
    chk("full_held", 32'(acc), 0);
    chk("full_mem_free0", 32'(mem_free), 0);
    cyc(1, 16'hF004, 1, 0, 0, 0, acc);
    chk("full_held_pop_cycle", 32'(acc), 0);
    cyc(1, 16'hF004, 0, 0, 0, 0, acc);
    chk("full_fifth_acc", 32'(acc), 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0, acc);

    // wrap: ten push/pop pairs through a four-word store
    for (int i = 0; i < 10; i++) begin
      cyc(1, 16'h5A00 + 16'(i), 1, 0, 0, 0, acc);
      chk("wrap_used_max", 32'(mem_used <= 4), 1);
    end
    cyc(0, 0, 1, 0, 0, 0, acc);
    cyc(0, 0, 1, 0, 0, 0, acc);

    // reset in the middle of a transaction with a done pending
    cyc(1, 16'h7001, 0, 0, 0, 0, acc);
    cyc(0, 0, 0, 1, 0, 0, acc);
    cyc(1, 16'h7002, 1, 0, 0, 0, acc);
    drive(1, 16'h7003, 1, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_push_done", 32'(push_done), 0);
    chk("midrst_pop_done", 32'(pop_done), 0);
    chk("midrst_mem_used", 32'(mem_used), 0);
    chk("midrst_mem_free", 32'(mem_free), DEPTH);
    store.delete(); pend.delete(); exp_q.delete(); readCnt = 0; inTxn = 0;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      w = 16'($urandom);
      cyc($urandom_range(0, 9) < 6, w, $urandom_range(0, 1),
          $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 19) == 0, acc);
    end
    if (inTxn) cyc(0, 0, 0, 0, 1, 0, acc);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 1, 0, 0, 0, acc);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_mem_used", 32'(mem_used), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mil_ring_buffer.md
MIL_RING_BUFFER -- requirements
Module: mil_ring_buffer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning log2 of storage depth (DEPTH = 2^ADDR_W words).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the word width (one MIL-STD-1553 data word).
REQ-003 The block SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port push_data  input  DATA_W  word to store.
REQ-006 The block SHALL have port push_req  input  1  producer requests a store of push_data.
REQ-007 The block SHALL have port push_done  output  1  one-cycle pulse: the word has been accepted.
REQ-008 The block SHALL have port pop_req  input  1  consumer requests the next word.
REQ-009 The block SHALL have port pop_data  output  DATA_W  read word, valid while pop_done=1.
REQ-010 The block SHALL have port pop_done  output  1  one-cycle pulse: pop_data is valid.
REQ-011 The block SHALL have port open  input  1  pulse: start a transaction.
REQ-012 The block SHALL have port commit  input  1  pulse: make the transaction's pushes/pops permanent.
REQ-013 The block SHALL have port rollback  input  1  pulse: undo the transaction's pushes/pops.
REQ-014 The block SHALL have port mem_used  output  ADDR_W+1  committed words available to the consumer.
REQ-015 The block SHALL have port mem_free  output  ADDR_W+1  words that can still be pushed.

Function
REQ-016 The block SHALL hold four pointers, each ADDR_W+1 bits and wrapping modulo 2^(ADDR_W+1): wr_c/rd_c (committed) and wr_t/rd_t (tentative).
REQ-017 The block SHALL drive mem_used = wr_c - rd_c and mem_free = DEPTH - (wr_t - rd_c), both combinational from the registered pointers.
REQ-018 A push SHALL be accepted in a cycle where push_req=1, mem_free>0 and rollback=0: mem[wr_t[ADDR_W-1:0]] <= push_data, wr_t increments, and push_done=1 in the next cycle.
REQ-019 A pop SHALL be accepted in a cycle where pop_req=1, rd_t != wr_c and rollback=0: rd_t increments, and in the next cycle pop_data = mem[old rd_t] with pop_done=1.
REQ-020 Pops SHALL see only committed words; an uncommitted push is never readable.
REQ-021 Requests that are not accepted SHALL produce no done pulse and no state change; the requester holds req until done.
REQ-022 Push and pop SHALL be accepted in the same cycle independently; back-to-back acceptance at one word per cycle per side SHALL be sustained.
REQ-023 The state machine SHALL have states IDLE (auto-commit) and TXN.
REQ-024 In IDLE, every accepted push/pop SHALL also advance wr_c/rd_c in the same cycle as wr_t/rd_t.
REQ-025 open in IDLE SHALL go to TXN; open in TXN SHALL be ignored.
REQ-026 In TXN, commit SHALL set wr_c<=wr_t and rd_c<=rd_t, including any push/pop accepted in that same cycle, and SHALL go to IDLE.
REQ-027 In TXN, rollback SHALL set wr_t<=wr_c and rd_t<=rd_c and go to IDLE; push and pop are not accepted in the rollback cycle.
REQ-028 commit or rollback in IDLE SHALL have no effect; rollback blocking accepts (REQ-018/019) SHALL apply in any state.
REQ-029 Priority within a cycle SHALL be rollback > commit > open; with open+commit both asserted, only the commit is acted on.
REQ-030 A pop_done for a read accepted before a rollback SHALL still be issued; that word is re-read after the rollback.
REQ-031 Storage SHALL be a single simple-dual-port array with synchronous read (block-RAM inferable), with no reset on the array.

Reset
REQ-032 On rst, all pointers SHALL be 0, the state SHALL be IDLE, push_done=0, pop_done=0, pop_data=0, mem_used=0 and mem_free=DEPTH.
REQ-033 rst asserted mid-transaction SHALL discard all data and pending dones, with no pulse in the cycle after reset.

Verification
REQ-034 IDLE: push 0x1111, 0x2222 on consecutive cycles -> push_done each next cycle, mem_used=2; then pop twice -> pop_data 0x1111 then 0x2222, mem_used=0.
REQ-035 Full: with ADDR_W=2, push 5 words -> 4 push_done, 5th held with mem_free=0; one pop -> 5th push accepted on the following cycle.
REQ-036 Commit: open, push 3 words -> mem_used stays 0 and pop_req gets no pop_done; commit -> mem_used=3.
REQ-037 Rollback: with 2 committed words, open, pop 1 and push 1, then rollback -> mem_used=2, mem_free=DEPTH-2, next pop returns the first word again.
REQ-038 Same-cycle events: push_req with commit -> word counted in mem_used after commit; push_req with rollback -> no push_done, pointers unchanged.
REQ-039 Wrap: with ADDR_W=2, run 10 push/pop pairs -> data order is preserved across pointer wrap, and mem_used never exceeds 4.
